// File: rtl/db_ram_1p_ctl_pkg.sv
// db_ram_1p_ctl_pkg
//   Shared definitions for the single-port RAM controller: the clear
//   sequencer state encoding (IDLE=0, CLEAR=1).
package db_ram_1p_ctl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/db_ram_1p_ctl_clr_seq.sv
// db_ram_clr_seq
//   Zero-fill sequencer. A clear request in IDLE loads the address counter
//   with 0; from the next cycle one write per cycle is issued to addresses
//   0..2^Addr_Width-1, then the sequencer returns to IDLE (no second pass).
// Ports
//   clk, rstn  clock, async active-low reset
//   clr_req    single-cycle clear request (ignored while busy)
//   busy       high for exactly 2^Addr_Width cycles while the clear runs
//   done       pulse on the cycle the last clear write is issued
//   wr_en      clear write strobe for the array
//   wr_addr    clear write address
module db_ram_clr_seq
  import db_ram_1p_ctl_pkg::*;
#(
  parameter int Addr_Width = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_en,
  output logic [Addr_Width-1:0] wr_addr
);

  clr_state_e            state_q, state_d;
  logic [Addr_Width-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        busy  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        // Last address: leave CLEAR; the counter wrap is harmless in IDLE.
        if (&cnt_q) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_en   = busy;
  assign wr_addr = cnt_q;

endmodule

// File: rtl/db_ram_1p_ctl.sv
// db_ram_1p_ctl
//   Single-port RAM controller: behavioural array with per-segment write
//   mask, registered read path (optional extra output stage), output-enable
//   gating and a zero-fill clear sequencer.
// Ports
//   clk, rstn      clock, async active-low reset
//   cen_i, wen_i   chip enable / write enable (active low); wen_i=1 reads
//   oen_i          output enable (active low); 1 forces data_o to zero
//   wm_i           per-segment write mask, 1 = segment written
//   addr_i, data_i word address, write data
//   clr_i          request to zero-fill the array
//   data_o, vld_o  read data (held between reads) and its one-cycle strobe
//   busy_o, done_o clear in progress / last clear write issued
module db_ram_1p_ctl
  import db_ram_1p_ctl_pkg::*;
#(
  parameter int Word_Width = 17,
  parameter int Addr_Width = 8,
  parameter int Seg_Num    = 1,
  parameter int Out_Reg    = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cen_i,
  input  logic                  oen_i,
  input  logic                  wen_i,
  input  logic [Seg_Num-1:0]    wm_i,
  input  logic [Addr_Width-1:0] addr_i,
  input  logic [Word_Width-1:0] data_i,
  input  logic                  clr_i,
  output logic [Word_Width-1:0] data_o,
  output logic                  vld_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int Seg_W  = Word_Width / Seg_Num;
  localparam int Depth  = 1 << Addr_Width;
  localparam int Stages = (Out_Reg != 0) ? 1 : 0;

  logic [Word_Width-1:0] mem [Depth];

  logic                  busy;
  logic                  clr_we;
  logic [Addr_Width-1:0] clr_addr;
  logic                  usr_we, usr_re;

  db_ram_clr_seq #(.Addr_Width(Addr_Width)) u_clr_seq (
    .clk     (clk),
    .rstn    (rstn),
    .clr_req (clr_i),
    .busy    (busy),
    .done    (done_o),
    .wr_en   (clr_we),
    .wr_addr (clr_addr)
  );

  assign busy_o = busy;

  // User accesses are locked out for the whole clear.
  assign usr_we = !cen_i && !wen_i && !busy;
  assign usr_re = !cen_i &&  wen_i && !busy;

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (usr_we) begin
      for (int k = 0; k < Seg_Num; k++) begin
        if (wm_i[k]) mem[addr_i][k*Seg_W +: Seg_W] <= data_i[k*Seg_W +: Seg_W];
      end
    end
  end

  // Read pipeline: stage 0 captures the array, optional stage 1 re-times it.
  // Each data stage only loads when its input is valid, so data_o holds.
  logic [Stages:0]                 vld_pipe;
  logic [Stages:0][Word_Width-1:0] data_pipe;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe[0]  <= 1'b0;
      data_pipe[0] <= '0;
    end else begin
      vld_pipe[0] <= usr_re;
      if (usr_re) data_pipe[0] <= mem[addr_i];
    end
  end

  for (genvar i = 1; i <= Stages; i++) begin : g_out_stage
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        vld_pipe[i]  <= 1'b0;
        data_pipe[i] <= '0;
      end else begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) data_pipe[i] <= data_pipe[i-1];
      end
    end
  end

  // Output enable only masks the pins; the held word survives underneath.
  assign data_o = oen_i ? '0 : data_pipe[Stages];
  assign vld_o  = vld_pipe[Stages];

endmodule

// File: tb/tb_db_ram_1p_ctl.sv
// tb_db_ram_1p_ctl
//   Two controllers share one stimulus stream: u0 with default parameters
//   (17-bit word, one segment, latency 1) and u1 with a 16-bit word, two
//   8-bit segments and the extra output stage (latency 2). A behavioural
//   model tracks memory contents, the clear window and the read results.
module tb_db_ram_1p_ctl;

  logic        clk  = 1'b0;
  logic        rstn = 1'b1;
  logic        cen  = 1'b1;
  logic        oen  = 1'b0;
  logic        wen  = 1'b1;
  logic        clr  = 1'b0;
  logic [1:0]  wm   = '0;
  logic [7:0]  addr = '0;
  logic [16:0] din  = '0;

  logic [16:0] dout0;
  logic [15:0] dout1;
  logic        vld0, vld1, busy0, busy1, done0, done1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  db_ram_1p_ctl u0 (
    .clk(clk), .rstn(rstn), .cen_i(cen), .oen_i(oen), .wen_i(wen),
    .wm_i(wm[0:0]), .addr_i(addr), .data_i(din), .clr_i(clr),
    .data_o(dout0), .vld_o(vld0), .busy_o(busy0), .done_o(done0)
  );

  db_ram_1p_ctl #(.Word_Width(16), .Addr_Width(8), .Seg_Num(2), .Out_Reg(1)) u1 (
    .clk(clk), .rstn(rstn), .cen_i(cen), .oen_i(oen), .wen_i(wen),
    .wm_i(wm), .addr_i(addr), .data_i(din[15:0]), .clr_i(clr),
    .data_o(dout1), .vld_o(vld1), .busy_o(busy1), .done_o(done1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [16:0] m0 [256];
  logic [15:0] m1 [256];
  bit          k0 [256];
  bit          k1 [256];
  int          clr_left = 0;
  int          clr_ptr  = 0;
  bit          e0_vld = 0, e1_vld = 0, p1_vld = 0;
  bit          e0_known = 1, e1_known = 1, p1_known = 1;
  logic [16:0] e0_hold = '0;
  logic [15:0] e1_hold = '0, p1_data = '0;

  always @(negedge rstn) begin
    clr_left = 0; clr_ptr = 0;
    e0_vld = 0; e1_vld = 0; p1_vld = 0;
    e0_hold = '0; e1_hold = '0; p1_data = '0;
    e0_known = 1; e1_known = 1; p1_known = 1;
    for (int a = 0; a < 256; a++) begin k0[a] = 0; k1[a] = 0; end
  end

  always @(posedge clk) begin
    if (rstn) begin
      int a;
      a = int'(addr);
      // latency-2 device: result of last cycle's read lands now
      e1_vld = p1_vld;
      if (p1_vld) begin e1_hold = p1_data; e1_known = p1_known; end
      p1_vld = 0;
      e0_vld = 0;
      if (clr_left > 0) begin
        m0[clr_ptr] = '0; m1[clr_ptr] = '0;
        k0[clr_ptr] = 1;  k1[clr_ptr] = 1;
        clr_ptr++;
        clr_left--;
      end else begin
        if (!cen && !wen) begin
          if (wm[0]) begin m0[a] = din; k0[a] = 1; end
          for (int s = 0; s < 2; s++)
            if (wm[s]) m1[a][s*8 +: 8] = din[s*8 +: 8];
          if (wm == 2'b11) k1[a] = 1;
        end else if (!cen && wen) begin
          e0_vld = 1; e0_hold = m0[a]; e0_known = k0[a];
          p1_vld = 1; p1_data = m1[a]; p1_known = k1[a];
        end
        if (clr) begin clr_left = 256; clr_ptr = 0; end
      end
    end
  end

  // compare process: every cycle, mid-period
  always @(negedge clk) begin
    chk("busy0", busy0, clr_left > 0);
    chk("busy1", busy1, clr_left > 0);
    chk("done0", done0, clr_left == 1);
    chk("done1", done1, clr_left == 1);
    chk("vld0", vld0, e0_vld);
    chk("vld1", vld1, e1_vld);
    if (oen) begin
      chk("data0_oen", dout0, 0);
      chk("data1_oen", dout1, 0);
    end else begin
      if (e0_known) chk("data0", dout0, e0_hold);
      if (e1_known) chk("data1", dout1, e1_hold);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic idle();
    cen = 1'b1; wen = 1'b1; clr = 1'b0; oen = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [16:0] d, input logic [1:0] m);
    cen = 1'b0; wen = 1'b0; addr = a; din = d; wm = m;
    cyc();
    idle();
  endtask

  task automatic rd(input logic [7:0] a);
    cen = 1'b0; wen = 1'b1; addr = a;
    cyc();
    idle();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy0 && n < 400) begin cyc(); n++; end
    chk("wait_idle", busy0, 0);
  endtask

  task automatic run_clear(input string tag, input bit traffic);
    int bc = 0, dc = 0;
    while (busy0 && bc < 300) begin
      bc++;
      if (done0) dc++;
      if (traffic) begin
        cen = 1'b0; wen = 1'($urandom_range(0, 1)); wm = 2'($urandom);
        addr = 8'($urandom); din = 17'($urandom); clr = 1'($urandom_range(0, 1));
      end
      cyc();
    end
    idle();
    chk({tag, "_busy_len"}, bc, 256);
    chk({tag, "_done_cnt"}, dc, 1);
  endtask

  logic [16:0] fill [256];

  initial begin
    #1 rstn = 1'b0;
    #1;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_vld0", vld0, 0);
    chk("rst_data0", dout0, 0);
    chk("rst_vld1", vld1, 0);
    chk("rst_data1", dout1, 0);
    repeat (2) cyc();
    rstn = 1'b1;
    cyc();

    // basic write/read, latency 1 on u0
    wr(8'd5, 17'h1ABCD, 2'b11);
    rd(8'd5);
    chk("r37_vld0", vld0, 1);
    chk("r37_data0", dout0, 17'h1ABCD);
    chk("r37_vld1_early", vld1, 0);
    cyc();
    chk("r37_vld0_pulse", vld0, 0);
    chk("r37_data1", dout1, 16'hABCD);

    // segment merge on u1
    wr(8'd3, 17'h0AAAA, 2'b11);
    wr(8'd3, 17'h05555, 2'b01);
    rd(8'd3);
    chk("r38_data0", dout0, 17'h05555);
    cyc();
    chk("r38_data1", dout1, 16'hAA55);

    // latency 2 and output enable masking on u1
    rd(8'd5);
    chk("r39_vld1_n1", vld1, 0);
    cyc();
    chk("r39_vld1_n2", vld1, 1);
    oen = 1'b1; #1;
    chk("r39_oen_data1", dout1, 0);
    chk("r39_oen_vld1", vld1, 1);
    oen = 1'b0; #1;
    chk("r39_data1", dout1, 16'hABCD);
    cyc();
    chk("r39_vld1_drop", vld1, 0);
    chk("r39_hold1", dout1, 16'hABCD);

    // randomized traffic, occasional clears
    repeat (1500) begin
      cen  = ($urandom_range(0, 9) < 7) ? 1'b0 : 1'b1;
      wen  = 1'($urandom_range(0, 1));
      wm   = 2'($urandom);
      addr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      din  = 17'($urandom);
      oen  = ($urandom_range(0, 4) == 0);
      clr  = ($urandom_range(0, 199) == 0);
      cyc();
    end
    idle();
    wait_idle();

    // fill, clear with a same-cycle read, traffic during busy
    for (int a = 0; a < 256; a++) begin
      fill[a] = 17'($urandom) | 17'h1;
      wr(8'(a), fill[a], 2'b11);
    end
    cen = 1'b0; wen = 1'b1; addr = 8'd7; clr = 1'b1;
    cyc();
    idle();
    chk("r30_vld0", vld0, 1);
    chk("r30_data0", dout0, fill[7]);
    chk("r24_busy_rise", busy0, 1);
    run_clear("r40", 1'b1);
    for (int a = 0; a < 256; a++) begin
      rd(8'(a));
      chk("r40_zero", dout0, 0);
    end
    cyc();

    // reset mid-clear
    wr(8'd9, 17'h0F0F1, 2'b11);
    rd(8'd9);
    chk("r41_pre_data0", dout0, 17'h0F0F1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    begin
      int dc = 0;
      repeat (100) begin
        if (done0) dc++;
        cyc();
      end
      chk("r41_busy_mid", busy0, 1);
      rstn = 1'b0; #1;
      chk("r41_busy", busy0, 0);
      chk("r41_done", done0, 0);
      chk("r41_vld0", vld0, 0);
      chk("r41_data0", dout0, 0);
      chk("r41_busy1", busy1, 0);
      chk("r41_data1", dout1, 0);
      chk("r41_no_done", dc, 0);
    end
    repeat (2) cyc();
    rstn = 1'b1;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    run_clear("r41", 1'b0);
    rd(8'd9);
    chk("r41_post_zero", dout0, 0);
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
